otter_ctrl_fsm_irq: RTL
=======================

Name: otter_ctrl_fsm_irq

Overview:
- Parametrised successor to the OTTER multicycle control FSM.
- Drives PC/regfile/memory/CSR strobes from the fetched instruction's opcode and funct3.
- Adds configurable memory read latency (wait states) for instruction and data reads.
- Adds NUM_IRQ prioritised, individually maskable interrupt sources with a latched cause and a per-source acknowledge.

Parameters:
- NUM_IRQ, 4: interrupt request lines; legal range 1..16.
- MEM_LAT, 1: memory read latency in cycles; legal range 1..8; 1 matches the existing single-cycle memory.
- CW, $clog2(NUM_IRQ) (minimum 1): width of irq_cause.

Ports:
- clk  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- opcode  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- irq  in  NUM_IRQ  level-sensitive interrupt requests.
- irq_en  in  NUM_IRQ  per-source enable mask (CSR mie).
- mie  in  1  global interrupt enable (mstatus[3]).
- reset  out  1  PC/CSR reset strobe.
- PC_WE  out  1  PC write enable.
- RF_WE  out  1  register file write enable.
- mem_WE2  out  1  data memory write enable.
- memRDEN1  out  1  instruction read enable.
- memRDEN2  out  1  data read enable.
- csr_WE  out  1  CSR write enable.
- int_taken  out  1  interrupt entry strobe.
- mret_exec  out  1  mret strobe.
- irq_cause  out  CW  index of the last taken interrupt (registered).
- irq_ack  out  NUM_IRQ  one-hot acknowledge to the taken source.
- state_dbg  out  3  current state encoding.

Behaviour:
- States: INIT, FETCH, FETCH_WAIT, EXEC, MEM_WAIT, WRITEBACK, INTR.
- Strobes are combinational from state, opcode and funct3. irq_cause and the wait counter are registered.
- Reset: on a clk edge with RST=1 the FSM enters INIT and clears the counter and irq_cause to 0.
  - In INIT: reset=1; every other strobe, irq_ack and int_taken = 0.
  - RST mid-operation aborts immediately. No partial writeback; strobes drop on the next cycle.
- INIT -> FETCH, unconditionally, after 1 cycle.
- FETCH: memRDEN1=1; counter loads MEM_LAT-1.
  - Counter==0 -> EXEC.
  - Otherwise -> FETCH_WAIT.
- FETCH_WAIT: memRDEN1=1; counter decrements; -> EXEC when counter reaches 0. Occupies MEM_LAT-1 cycles.
- EXEC, decoded by opcode:
  - LOAD 0000011: memRDEN2=1; PC_WE=0; counter loads MEM_LAT-1. -> MEM_WAIT if MEM_LAT>1, else -> WRITEBACK.
  - STORE 0100011: mem_WE2=1, PC_WE=1.
  - BRANCH 1100011: PC_WE=1.
  - LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, OP_IMM 0010011, OP 0110011: RF_WE=1, PC_WE=1.
  - SYSTEM 1110011, funct3=000: mret_exec=1, PC_WE=1.
  - SYSTEM 1110011, funct3 001/010/011: csr_WE=1, RF_WE=1, PC_WE=1.
  - SYSTEM 1110011, any other funct3: PC_WE=1 only.
  - Unknown opcode: PC_WE=1 only (NOP).
- MEM_WAIT: memRDEN2=1; counter decrements; -> WRITEBACK at 0. Occupies MEM_LAT-1 cycles.
- WRITEBACK: RF_WE=1, PC_WE=1.
- Interrupt decision: made in the final cycle of an instruction, i.e. EXEC for non-loads and WRITEBACK for loads.
  - pend = irq & irq_en.
  - take = mie & |pend.
  - take=1 -> INTR, and irq_cause latches the lowest set index of pend (index 0 has highest priority).
  - take=0 -> FETCH.
- INTR (1 cycle): int_taken=1, PC_WE=1, irq_ack = one-hot of the latched irq_cause. -> FETCH.
  - A new interrupt is never evaluated in INTR or in FETCH/FETCH_WAIT/MEM_WAIT.
- Simultaneous events:
  - mret in EXEC with take=1: mret_exec still asserts that cycle, then -> INTR.
  - A request arriving during a load's EXEC/MEM_WAIT is honoured only if still pending at WRITEBACK.
- Widths: the wait counter is $clog2(MEM_LAT+1) bits and never wraps, since it reloads on entry to each wait sequence.
- irq_cause holds its value between interrupts.

Decomposition:
- Package otter_ctrl_pkg:
  - state enum (3-bit encoding) for the seven states.
  - Opcode localparams: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, SYSTEM.
  - SYSTEM funct3 constants: MRET=000, CSRRW=001, CSRRS=010, CSRRC=011.
- Sub-module irq_prio_enc: NUM_IRQ-bit input -> CW-bit index plus valid; purely combinational, lowest index wins.

Test Plan:
1. MEM_LAT=1, RST pulse, then OP 0110011 -> INIT 1 cycle with reset=1; FETCH memRDEN1=1; EXEC RF_WE=PC_WE=1; repeating 2-cycle loop.
2. MEM_LAT=3, LOAD 0000011 -> FETCH, FETCH_WAIT x2, EXEC memRDEN2=1/PC_WE=0, MEM_WAIT x2, WRITEBACK RF_WE=PC_WE=1; 7 cycles total.
3. NUM_IRQ=4, irq=4'b0110, irq_en=4'hF, mie=1 during OP EXEC -> next state INTR: int_taken=1, PC_WE=1, irq_cause=1, irq_ack=4'b0010; then FETCH.
4. Same irq with irq_en=4'b1001, or with mie=0 -> no INTR; EXEC -> FETCH; irq_cause keeps its prior value.
5. SYSTEM funct3=000 -> mret_exec=1, PC_WE=1, RF_WE=0; SYSTEM funct3=001 -> csr_WE=1, RF_WE=1, PC_WE=1.
6. MEM_LAT=3, RST=1 in the first MEM_WAIT cycle -> next cycle INIT: reset=1, memRDEN2=0, RF_WE=0, irq_cause=0; WRITEBACK never reached.

Source files
------------

// File: rtl/otter_ctrl_pkg.sv
// Shared definitions for the OTTER multicycle control FSM with interrupts:
// state encoding, RV32I major opcodes and SYSTEM funct3 codes.
package otter_ctrl_pkg;

    typedef enum logic [2:0] {
        INIT       = 3'd0,
        FETCH      = 3'd1,
        FETCH_WAIT = 3'd2,
        EXEC       = 3'd3,
        MEM_WAIT   = 3'd4,
        WRITEBACK  = 3'd5,
        INTR       = 3'd6
    } state_t;

    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    localparam logic [2:0] MRET  = 3'b000;
    localparam logic [2:0] CSRRW = 3'b001;
    localparam logic [2:0] CSRRS = 3'b010;
    localparam logic [2:0] CSRRC = 3'b011;

endpackage

// File: rtl/otter_ctrl_fsm_irq_prio_enc.sv
// Fixed-priority encoder for interrupt requests: the lowest set index wins.
module irq_prio_enc #(
    parameter int NUM_IRQ = 4,
    parameter int CW      = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic [CW-1:0]      idx,
    output logic               valid
);

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (req[i] && !valid) begin
                idx   = CW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/otter_ctrl_fsm_irq.sv
// OTTER multicycle control FSM with memory wait states and prioritised,
// maskable interrupts. Strobes are combinational from state/opcode/funct3.
module otter_ctrl_fsm_irq
    import otter_ctrl_pkg::*;
#(
    parameter int NUM_IRQ = 4,
    parameter int MEM_LAT = 1,
    parameter int CW      = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               RST,
    input  logic [6:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irq_en,
    input  logic               mie,
    output logic               reset,
    output logic               PC_WE,
    output logic               RF_WE,
    output logic               mem_WE2,
    output logic               memRDEN1,
    output logic               memRDEN2,
    output logic               csr_WE,
    output logic               int_taken,
    output logic               mret_exec,
    output logic [CW-1:0]      irq_cause,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic [2:0]         state_dbg
);

    localparam int              CNTW     = $clog2(MEM_LAT + 1);
    localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(MEM_LAT - 1);

    state_t            state, state_nx;
    logic [CNTW-1:0]   cnt, cnt_nx;
    logic [CW-1:0]     cause_q, cause_nx;
    logic [NUM_IRQ-1:0] pend;
    logic [CW-1:0]     pend_idx;
    logic              pend_any;
    logic              take;

    assign pend = irq & irq_en;
    assign take = mie & pend_any;

    irq_prio_enc #(
        .NUM_IRQ(NUM_IRQ),
        .CW     (CW)
    ) u_prio (
        .req  (pend),
        .idx  (pend_idx),
        .valid(pend_any)
    );

    always_ff @(posedge clk) begin
        if (RST) begin
            state   <= INIT;
            cnt     <= '0;
            cause_q <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            cause_q <= cause_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        cause_nx  = cause_q;
        reset     = 1'b0;
        PC_WE     = 1'b0;
        RF_WE     = 1'b0;
        mem_WE2   = 1'b0;
        memRDEN1  = 1'b0;
        memRDEN2  = 1'b0;
        csr_WE    = 1'b0;
        int_taken = 1'b0;
        mret_exec = 1'b0;
        irq_ack   = '0;

        case (state)
            INIT: begin
                reset    = 1'b1;
                state_nx = FETCH;
            end
            FETCH: begin
                memRDEN1 = 1'b1;
                cnt_nx   = CNT_LOAD;
                state_nx = (CNT_LOAD == '0) ? EXEC : FETCH_WAIT;
            end
            FETCH_WAIT: begin
                memRDEN1 = 1'b1;
                cnt_nx   = (cnt != '0) ? cnt - CNTW'(1) : '0;
                if (cnt <= CNTW'(1)) state_nx = EXEC;
            end
            EXEC: begin
                if (opcode == LOAD) begin
                    memRDEN2 = 1'b1;
                    cnt_nx   = CNT_LOAD;
                    state_nx = (CNT_LOAD == '0) ? WRITEBACK : MEM_WAIT;
                end else begin
                    PC_WE = 1'b1;
                    case (opcode)
                        STORE:  mem_WE2 = 1'b1;
                        LUI, AUIPC, JAL, JALR, OP_IMM, OP: RF_WE = 1'b1;
                        SYSTEM: begin
                            case (funct3)
                                MRET: mret_exec = 1'b1;
                                CSRRW, CSRRS, CSRRC: begin
                                    csr_WE = 1'b1;
                                    RF_WE  = 1'b1;
                                end
                                default: ;
                            endcase
                        end
                        default: ;
                    endcase
                    // Last cycle of a non-load instruction: interrupt decision point
                    if (take) begin
                        state_nx = INTR;
                        cause_nx = pend_idx;
                    end else begin
                        state_nx = FETCH;
                    end
                end
            end
            MEM_WAIT: begin
                memRDEN2 = 1'b1;
                cnt_nx   = (cnt != '0) ? cnt - CNTW'(1) : '0;
                if (cnt <= CNTW'(1)) state_nx = WRITEBACK;
            end
            WRITEBACK: begin
                RF_WE = 1'b1;
                PC_WE = 1'b1;
                if (take) begin
                    state_nx = INTR;
                    cause_nx = pend_idx;
                end else begin
                    state_nx = FETCH;
                end
            end
            INTR: begin
                int_taken = 1'b1;
                PC_WE     = 1'b1;
                for (int unsigned i = 0; i < NUM_IRQ; i++) begin
                    irq_ack[i] = (CW'(i) == cause_q);
                end
                state_nx = FETCH;
            end
            default: state_nx = INIT;
        endcase
    end

    assign irq_cause = cause_q;
    assign state_dbg = state;

endmodule
